// File: rtl/ldq_commit_tracker_if.sv
// Load-queue commit tracker bus: dispatch/commit load masks in,
// head/tail/occupancy and per-slot LDQ indices out.
// Optional macro LDQ_COMMIT_CHECK_EN adds the sticky ldqError_o flag.
interface ldq_commit_tracker_if #(
  parameter int unsigned COMMIT_WIDTH   = 4,
  parameter int unsigned DISPATCH_WIDTH = 4,
  parameter int unsigned LDQ_DEPTH      = 32,
  parameter int unsigned LDQ_LOG        = $clog2(LDQ_DEPTH),
  parameter int unsigned CNT_W          = $clog2(LDQ_DEPTH + 1),
  parameter int unsigned CC_W           = $clog2(COMMIT_WIDTH + 1)
);
  logic [COMMIT_WIDTH-1:0]                 commitLoad_i;
  logic [DISPATCH_WIDTH-1:0]               dispLoad_i;
  logic                                    recover_i;
  logic [LDQ_LOG-1:0]                      ldqHead_o;
  logic [LDQ_LOG-1:0]                      ldqTail_o;
  logic [CNT_W-1:0]                        ldqCount_o;
  logic [CNT_W-1:0]                        ldqFree_o;
  logic                                    ldqStall_o;
  logic [CC_W-1:0]                         commitLdCount_o;
  logic [COMMIT_WIDTH-1:0][LDQ_LOG-1:0]    commitLdIndex_o;
  logic [DISPATCH_WIDTH-1:0][LDQ_LOG-1:0]  dispLdIndex_o;
`ifdef LDQ_COMMIT_CHECK_EN
  logic                                    ldqError_o;
`endif

  // Tracker side
  modport slave (
`ifdef LDQ_COMMIT_CHECK_EN
    output ldqError_o,
`endif
    input  commitLoad_i, dispLoad_i, recover_i,
    output ldqHead_o, ldqTail_o, ldqCount_o, ldqFree_o, ldqStall_o,
    output commitLdCount_o, commitLdIndex_o, dispLdIndex_o
  );

  // Dispatch/retire side
  modport master (
`ifdef LDQ_COMMIT_CHECK_EN
    input  ldqError_o,
`endif
    output commitLoad_i, dispLoad_i, recover_i,
    input  ldqHead_o, ldqTail_o, ldqCount_o, ldqFree_o, ldqStall_o,
    input  commitLdCount_o, commitLdIndex_o, dispLdIndex_o
  );
endinterface

// File: rtl/ldq_commit_tracker.sv
// Load-queue head/tail/occupancy bookkeeping with explicit modulo wrap
// (non-power-of-two depths), underflow saturation and squash recovery.
// Optional macro LDQ_COMMIT_CHECK_EN enables the sticky ldqError_o checker.
module ldq_commit_tracker #(
  parameter int unsigned COMMIT_WIDTH   = 4,
  parameter int unsigned DISPATCH_WIDTH = 4,
  parameter int unsigned LDQ_DEPTH      = 32,
  parameter int unsigned LDQ_LOG        = $clog2(LDQ_DEPTH),
  parameter int unsigned CNT_W          = $clog2(LDQ_DEPTH + 1)
) (
  input logic                  clk,
  input logic                  reset_n,
  ldq_commit_tracker_if.slave  io_ldq
);
  localparam int unsigned CC_W  = $clog2(COMMIT_WIDTH + 1);
  localparam int unsigned DC_W  = $clog2(DISPATCH_WIDTH + 1);
  localparam int unsigned IDX_W = LDQ_LOG + 1;

  logic [LDQ_LOG-1:0] r_head;
  logic [LDQ_LOG-1:0] r_tail;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_free;
  logic               r_stall;

  logic [CC_W-1:0]    w_commit_cnt;
  logic [DC_W-1:0]    w_disp_cnt;
  logic               w_underflow;
  logic [CNT_W-1:0]   w_commit_eff;
  logic [CNT_W-1:0]   w_disp_eff;
  logic [LDQ_LOG-1:0] w_head_next;
  logic [LDQ_LOG-1:0] w_tail_next;
  logic [CNT_W-1:0]   w_count_next;
  logic [CNT_W-1:0]   w_free_next;
  logic [COMMIT_WIDTH-1:0][LDQ_LOG-1:0]   w_commit_idx;
  logic [DISPATCH_WIDTH-1:0][LDQ_LOG-1:0] w_disp_idx;

  // Wrap a pointer sum (always < 2*LDQ_DEPTH) back into [0, LDQ_DEPTH)
  function automatic logic [LDQ_LOG-1:0] f_wrap(input logic [IDX_W-1:0] s);
    if (s >= IDX_W'(LDQ_DEPTH)) begin
      return LDQ_LOG'(s - IDX_W'(LDQ_DEPTH));
    end
    return LDQ_LOG'(s);
  endfunction

  // Popcounts of retiring and dispatching load slots
  always_comb begin
    w_commit_cnt = '0;
    w_disp_cnt   = '0;
    for (int k = 0; k < int'(COMMIT_WIDTH); k++) begin
      w_commit_cnt = w_commit_cnt + CC_W'(io_ldq.commitLoad_i[k]);
    end
    for (int k = 0; k < int'(DISPATCH_WIDTH); k++) begin
      w_disp_cnt = w_disp_cnt + DC_W'(io_ldq.dispLoad_i[k]);
    end
  end

  // Per-slot LDQ indices relative to current head/tail
  always_comb begin
    w_commit_idx = '0;
    w_disp_idx   = '0;
    for (int k = 0; k < int'(COMMIT_WIDTH); k++) begin
      w_commit_idx[k] = f_wrap(IDX_W'(r_head) + IDX_W'(k));
    end
    for (int k = 0; k < int'(DISPATCH_WIDTH); k++) begin
      w_disp_idx[k] = f_wrap(IDX_W'(r_tail) + IDX_W'(k));
    end
  end

  // Next pointer/occupancy: commits saturate at count, dispatch gated by stall/recover
  always_comb begin
    w_underflow  = CNT_W'(w_commit_cnt) > r_count;
    w_commit_eff = w_underflow ? r_count : CNT_W'(w_commit_cnt);
    w_disp_eff   = (!r_stall && !io_ldq.recover_i) ? CNT_W'(w_disp_cnt) : '0;
    w_head_next  = f_wrap(IDX_W'(r_head) + IDX_W'(w_commit_eff));
    w_tail_next  = f_wrap(IDX_W'(r_tail) + IDX_W'(w_disp_eff));
    w_count_next = r_count - w_commit_eff + w_disp_eff;
    if (io_ldq.recover_i) begin
      w_tail_next  = w_head_next;
      w_count_next = '0;
    end
    w_free_next = CNT_W'(LDQ_DEPTH) - w_count_next;
  end

  // Pointer, occupancy, free and stall registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_free  <= CNT_W'(LDQ_DEPTH);
      r_stall <= 1'b0;
    end else begin
      r_head  <= w_head_next;
      r_tail  <= w_tail_next;
      r_count <= w_count_next;
      r_free  <= w_free_next;
      r_stall <= w_free_next < CNT_W'(DISPATCH_WIDTH);
    end
  end

`ifdef LDQ_COMMIT_CHECK_EN
  logic                  r_error;
  logic [COMMIT_WIDTH:0] w_commit_p1;
  logic                  w_noncontig;
  logic                  w_disp_violation;

  // A contiguous low-order prefix x satisfies (x+1) & x == 0
  always_comb begin
    w_commit_p1      = {1'b0, io_ldq.commitLoad_i} + (COMMIT_WIDTH + 1)'(1);
    w_noncontig      = |(w_commit_p1[COMMIT_WIDTH-1:0] & io_ldq.commitLoad_i);
    w_disp_violation = (|io_ldq.dispLoad_i) && r_stall && !io_ldq.recover_i;
  end

  // Sticky protocol error flag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_error <= 1'b0;
    end else begin
      r_error <= r_error | w_underflow | w_disp_violation | w_noncontig;
    end
  end

  assign io_ldq.ldqError_o = r_error;
`endif

  assign io_ldq.ldqHead_o       = r_head;
  assign io_ldq.ldqTail_o       = r_tail;
  assign io_ldq.ldqCount_o      = r_count;
  assign io_ldq.ldqFree_o       = r_free;
  assign io_ldq.ldqStall_o      = r_stall;
  assign io_ldq.commitLdCount_o = w_commit_cnt;
  assign io_ldq.commitLdIndex_o = w_commit_idx;
  assign io_ldq.dispLdIndex_o   = w_disp_idx;
endmodule
